// File: rtl/efc_pkg.sv
// efc_pkg: shared constants, width helper and channel index type for the efuse TCK data register
package efc_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM_CH = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int DEF_CH_W = clog2(DEF_NUM_CH);
  typedef logic [DEF_CH_W-1:0] ch_idx_t;
endpackage

// File: rtl/dff_ns.sv
// dff_ns: plain non-reset flop; callers fold reset into d
module dff_ns #(parameter int W = 1) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= d;
endmodule

// File: rtl/efc_tck_cnt.sv
// efc_tck_cnt: saturating shift counter with clear and increment
module efc_tck_cnt #(parameter int W = 6) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = (rst || clr) ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  dff_ns #(.W(W)) u_cnt (.clk(clk), .d(cnt_d), .q(cnt_q));
  assign cnt = cnt_q;
endmodule

// File: rtl/efc_tck_dr.sv
// efc_tck_dr: multi-channel TCK-domain JTAG data register with length-checked update and bypass
module efc_tck_dr
  import efc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
  parameter int CNT_W     = clog2(WIDTH + 1),
  parameter int LSB_FIRST = 0
) (
  input  logic                    tck,
  input  logic                    tck_rst,
  input  logic [CH_W-1:0]         ctu_efc_chsel,
  input  logic [NUM_CH*WIDTH-1:0] read_data_ff,
  input  logic                    ctu_efc_data_in,
  input  logic                    ctu_efc_capturedr,
  input  logic                    ctu_efc_shiftdr,
  input  logic                    ctu_efc_updatedr,
  output logic                    efc_ctu_data_out,
  output logic [WIDTH-1:0]        tck_shft_data_ff,
  output logic [WIDTH-1:0]        tck_upd_data_ff,
  output logic [CH_W-1:0]         tck_upd_ch_ff,
  output logic                    tck_upd_vld,
  output logic [CNT_W-1:0]        tck_shft_cnt_ff,
  output logic                    tck_shft_err_ff
);
  logic valid_ch, cap, shf, upd, len_ok;
  logic [WIDTH-1:0] cap_data, shifted;
  logic [WIDTH-1:0] shft_d, shft_q, upd_data_d, upd_data_q;
  logic [CH_W-1:0] upd_ch_d, upd_ch_q;
  logic byp_d, byp_q, upd_vld_d, upd_vld_q, err_d, err_q;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    valid_ch   = 32'(ctu_efc_chsel) < NUM_CH;
    cap        = ctu_efc_capturedr;
    shf        = !cap && ctu_efc_shiftdr;
    upd        = !cap && !ctu_efc_shiftdr && ctu_efc_updatedr && valid_ch;
    len_ok     = cnt == CNT_W'(WIDTH);
    cap_data   = read_data_ff[32'(ctu_efc_chsel)*WIDTH +: WIDTH];
    shifted    = (LSB_FIRST != 0) ? {ctu_efc_data_in, shft_q[WIDTH-1:1]}
                                  : {shft_q[WIDTH-2:0], ctu_efc_data_in};
    shft_d     = tck_rst ? '0 : (cap && valid_ch) ? cap_data : (shf && valid_ch) ? shifted : shft_q;
    byp_d      = tck_rst ? 1'b0 : (cap && !valid_ch) ? 1'b0 : (shf && !valid_ch) ? ctu_efc_data_in : byp_q;
    upd_data_d = tck_rst ? '0 : (upd && len_ok) ? shft_q : upd_data_q;
    upd_ch_d   = tck_rst ? '0 : (upd && len_ok) ? ctu_efc_chsel : upd_ch_q;
    upd_vld_d  = !tck_rst && upd && len_ok;
    err_d      = !tck_rst && (err_q || (upd && !len_ok));
  end
  efc_tck_cnt #(.W(CNT_W)) u_cnt (
    .clk(tck), .rst(tck_rst), .clr(cap && valid_ch), .inc(shf && valid_ch), .cnt(cnt)
  );
  dff_ns #(.W(WIDTH)) u_shft     (.clk(tck), .d(shft_d),     .q(shft_q));
  dff_ns #(.W(WIDTH)) u_upd_data (.clk(tck), .d(upd_data_d), .q(upd_data_q));
  dff_ns #(.W(CH_W))  u_upd_ch   (.clk(tck), .d(upd_ch_d),   .q(upd_ch_q));
  dff_ns #(.W(3))     u_flags    (.clk(tck), .d({byp_d, upd_vld_d, err_d}), .q({byp_q, upd_vld_q, err_q}));
  assign efc_ctu_data_out = !valid_ch ? byp_q : (LSB_FIRST != 0) ? shft_q[0] : shft_q[WIDTH-1];
  assign tck_shft_data_ff = shft_q;
  assign tck_upd_data_ff  = upd_data_q;
  assign tck_upd_ch_ff    = upd_ch_q;
  assign tck_upd_vld      = upd_vld_q;
  assign tck_shft_cnt_ff  = cnt;
  assign tck_shft_err_ff  = err_q;
endmodule

// File: doc/efc_tck_dr.md
Name: efc_tck_dr

Overview:
- Parametrised successor of the efuse TCK-domain shift data register.
- Multi-channel JTAG data register in the efuse cluster, clocked by tck.
- Captures one of NUM_CH read registers, shifts it serially to and from the CTU, and updates a write-back register on updatedr.
- Adds a shifted-bit counter, length-checked update, bypass on an unmapped channel and a selectable shift direction.

Parameters:
- WIDTH, 32, shift/update register width in bits (>=2).
- NUM_CH, 4, number of selectable capture sources (>=1).
- CH_W, 2, channel select width; 2^CH_W >= NUM_CH.
- CNT_W, 6, shift counter width; 2^CNT_W-1 >= WIDTH.
- LSB_FIRST, 0: 0 = shift left, serial out = MSB (legacy); 1 = shift right, serial out = LSB.

Ports:
- tck  in  1  JTAG test clock; sole clock.
- tck_rst  in  1  synchronous active-high reset.
- ctu_efc_chsel  in  CH_W  channel select; held stable from capture through update.
- read_data_ff  in  NUM_CH*WIDTH  capture sources; channel k = bits [k*WIDTH +: WIDTH].
- ctu_efc_data_in  in  1  serial in from CTU.
- ctu_efc_capturedr  in  1  capture strobe.
- ctu_efc_shiftdr  in  1  shift enable.
- ctu_efc_updatedr  in  1  update strobe.
- efc_ctu_data_out  out  1  serial out to CTU.
- tck_shft_data_ff  out  WIDTH  shift register contents.
- tck_upd_data_ff  out  WIDTH  last accepted update value.
- tck_upd_ch_ff  out  CH_W  channel of last accepted update.
- tck_upd_vld  out  1  one-cycle pulse: update accepted.
- tck_shft_cnt_ff  out  CNT_W  bits shifted since last capture.
- tck_shft_err_ff  out  1  sticky length-mismatch flag.

Behaviour:
- One clock (tck). Reset is synchronous and active-high (tck_rst).
- Reset values: all registered outputs 0, bypass bit 0, tck_upd_vld 0.
- valid_ch = (ctu_efc_chsel < NUM_CH). Control priority per cycle: capturedr > shiftdr > updatedr.
- Capture:
  - valid_ch: shift reg <= selected channel; cnt <= 0.
  - Invalid channel: bypass bit <= 0; shift reg and cnt hold.
- Shift, valid_ch:
  - LSB_FIRST=0: shift reg <= {shft[WIDTH-2:0], data_in}.
  - LSB_FIRST=1: shift reg <= {data_in, shft[WIDTH-1:1]}.
  - cnt increments and saturates at 2^CNT_W-1 (no wrap).
- Shift, invalid channel: bypass bit <= data_in; shift reg and cnt hold.
- Update with no capture or shift that cycle, valid_ch:
  - cnt == WIDTH: upd_data <= shift reg, upd_ch <= chsel, tck_upd_vld = 1 next cycle only.
  - cnt != WIDTH: no update, no pulse, tck_shft_err_ff <= 1.
- Update on an invalid channel: ignored; no error.
- Update asserted together with capture or shift: ignored; no error.
- tck_shft_err_ff is cleared only by reset.
- efc_ctu_data_out selection:
  - Invalid channel: bypass bit.
  - LSB_FIRST=0: shft[WIDTH-1].
  - LSB_FIRST=1: shft[0].
  - Combinational from flops only; no path from data_in to data_out.
- Latency: capture visible on data_out the next cycle; update pulse one cycle after updatedr is sampled.
- Strobes held multiple cycles:
  - Repeated capture reloads.
  - Repeated update re-checks cnt; a second pulse is allowed when cnt is still WIDTH.
- Reset mid-shift: all state is cleared; a subsequent update without capture and WIDTH shifts sets err.

Decomposition:
- Shared package efc_pkg holds:
  - default WIDTH/NUM_CH constants;
  - a clog2-style function for CH_W/CNT_W;
  - the channel index type.
- One natural sub-module: efc_tck_cnt, the saturating shift counter with clear/increment.
- Flops use the library dff_ns with the reset muxed in ahead of the flop.

Test Plan:
- Capture ch1 = 32'hA5A5_0F0F, 32 shifts with data_in=0 (LSB_FIRST=0) -> data_out MSB-first 1,0,1,0,0,1,0,1...; shft ends 32'h0; cnt = 32.
- Capture ch2, shift in 32'hDEAD_BEEF MSB-first, updatedr -> upd_data = 32'hDEAD_BEEF, upd_ch = 2, vld pulse exactly 1 cycle, err = 0.
- Capture, 31 shifts, updatedr -> no vld, upd_data unchanged, err = 1 and still 1 after a later good update.
- chsel = 3 with NUM_CH=3: capture, shift 1,1,0 -> data_out = 0,1,1 (one-bit delay); shft and cnt unchanged; updatedr -> no vld, no err.
- LSB_FIRST=1: capture 32'h0000_0001 -> first data_out = 1, then 0; capture+shift asserted together -> capture wins; shift+update together -> update ignored.
- Shift 70 times with CNT_W=6 -> cnt saturates at 63; tck_rst asserted mid-shift -> all outputs 0 on the next edge.
